reg_bus_initiator: RTL and testbench
====================================

Name: reg_bus_initiator

Overview:
- Register-interface initiator: the requester end of the reg_req/reg_rsp protocol served by soc_ctrl, fast_intr_ctrl and the UART register slaves.
- Accepts single-beat commands on a valid/ready stream, drives exactly one reg bus transaction per command, and returns read data and status on a valid/ready response stream.
- Adds a bus-hang timeout and transaction/error counters. Intended for a debug/loader agent driving the peripheral register bus.

Parameters:
- AddrWidth, 32, reg bus address width.
- DataWidth, 32, reg bus data width; wstrb width is DataWidth/8.
- TimeoutCycles, 1024, maximum cycles in REQ before the transaction is abandoned; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_addr_i  in  AddrWidth  target address.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_wdata_i  in  DataWidth  write data.
- cmd_wstrb_i  in  DataWidth/8  byte strobes.
- reg_valid_o  out  1  reg_req.valid.
- reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o  out  AddrWidth/1/DataWidth/DataWidth/8  reg_req fields.
- reg_ready_i  in  1  reg_rsp.ready.
- reg_rdata_i  in  DataWidth  reg_rsp.rdata.
- reg_error_i  in  1  reg_rsp.error.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DataWidth  read data; 0 for writes and timeouts.
- rsp_error_o  out  1  slave error or timeout.
- rsp_timeout_o  out  1  transaction abandoned by timeout.
- busy_o  out  1  state != IDLE.
- txn_cnt_o  out  16  completed responses; wraps from 0xFFFF to 0.
- err_cnt_o  out  8  responses with rsp_error_o = 1; saturates at 0xFF.

Behaviour:
- Reset (rst_i high at a rising edge):
  - state = IDLE; all registered outputs are 0, including reg_*_o, rsp_*_o, txn_cnt_o and err_cnt_o.
  - Reset mid-transaction abandons it: reg_valid_o is low from the next cycle, and no response is produced.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, capture addr/write/wdata/wstrb into holding registers, clear the timeout counter, and go to REQ.
- REQ:
  - reg_valid_o = 1. All reg_*_o fields come from the holding registers and stay stable until ready.
  - If reg_ready_i = 1:
    - capture reg_rdata_i (reads) or 0 (writes);
    - rsp_error_o = reg_error_i, rsp_timeout_o = 0;
    - go to RSP.
  - Otherwise the timeout counter increments. When it reaches TimeoutCycles (and TimeoutCycles != 0), with reg_ready_i still low:
    - drop reg_valid_o next cycle;
    - rsp_rdata_o = 0, rsp_error_o = 1, rsp_timeout_o = 1;
    - go to RSP.
  - reg_ready_i in the same cycle as the timeout expiry takes priority: normal completion, no timeout.
- RSP:
  - rsp_valid_o = 1; rsp_rdata_o, rsp_error_o and rsp_timeout_o stay stable until rsp_ready_i.
  - On rsp_ready_i: txn_cnt_o += 1; err_cnt_o += rsp_error_o (saturating).
  - cmd_ready_o = rsp_ready_i (combinational), allowing back-to-back commands.
  - If rsp_ready_i and cmd_valid_i: capture the new command and go directly to REQ.
  - Else if rsp_ready_i: go to IDLE.
- Latency, zero-wait slave (ready in the first REQ cycle):
  - command accepted at edge N;
  - reg_valid_o high in cycle N+1;
  - rsp_valid_o high in cycle N+2.
  - Sustained throughput: one transaction per 2 cycles.
- Bus rules:
  - At most one outstanding transaction.
  - reg_valid_o is never asserted outside REQ.
  - reg_*_o fields are held in IDLE/RSP at their last values; do not use them when reg_valid_o = 0.
- No address alignment or strobe checking; fields pass through unmodified.

Test Plan:
- Write, zero-wait slave: cmd write addr 0x0000_0010, wdata 0xDEAD_BEEF, wstrb 0xF.
  - Required: reg_valid_o for 1 cycle with those fields; rsp_valid_o 2 cycles after accept; rdata 0, error 0; txn_cnt_o = 1.
- Read with 3 wait states: slave returns 0x1234_5678 after 3 cycles.
  - Required: reg fields held stable for 4 cycles; rsp_rdata_o = 0x1234_5678; error 0.
- Slave error: read, reg_error_i = 1.
  - Required: rsp_error_o = 1, rsp_timeout_o = 0, err_cnt_o = 1.
- Timeout, TimeoutCycles = 8, slave never ready.
  - Required: reg_valid_o high for exactly 8 cycles, then low; rsp_error_o = 1, rsp_timeout_o = 1, rdata 0.
  - Repeat with ready arriving on the expiry cycle: normal completion.
- Back-to-back with backpressure: 3 commands queued, rsp_ready_i low for 5 cycles on the 2nd response.
  - Required: no new reg_valid_o while RSP is stalled; responses are in order; txn_cnt_o = 3.
- Reset in REQ: assert rst_i while the slave is stalling.
  - Required: reg_valid_o = 0 and busy_o = 0 next cycle; no rsp_valid_o; counters = 0.
  - Also required: err_cnt_o saturates at 0xFF after 300 errors; txn_cnt_o wraps 0xFFFF -> 0.

Source files
------------

// File: rtl/reg_bus_initiator.sv
// reg_bus_initiator
//   Requester end of the reg_req/reg_rsp register bus. Each command taken on
//   the cmd stream becomes exactly one reg bus transaction. The result comes
//   back on the rsp stream. A REQ-phase watchdog abandons a transaction whose
//   slave never answers. Counters track completed responses and errors.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_addr_i, cmd_write_i,
//   cmd_wdata_i, cmd_wstrb_i     command fields
//   reg_valid_o, reg_addr_o,
//   reg_write_o, reg_wdata_o,
//   reg_wstrb_o                  reg_req (fields valid only with reg_valid_o)
//   reg_ready_i, reg_rdata_i,
//   reg_error_i                  reg_rsp
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_rdata_o, rsp_error_o,
//   rsp_timeout_o                response fields
//   busy_o                       transaction in flight or response pending
//   txn_cnt_o                    completed responses (wrapping)
//   err_cnt_o                    responses with error (saturating)
//
// state | meaning
// IDLE  | waiting for a command
// REQ   | reg_valid_o asserted, waiting for reg_ready_i or timeout
// RSP   | response presented, waiting for rsp_ready_i
module reg_bus_initiator #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic                   cmd_write_i,
  input  logic [DataWidth-1:0]   cmd_wdata_i,
  input  logic [DataWidth/8-1:0] cmd_wstrb_i,
  output logic                   reg_valid_o,
  output logic [AddrWidth-1:0]   reg_addr_o,
  output logic                   reg_write_o,
  output logic [DataWidth-1:0]   reg_wdata_o,
  output logic [DataWidth/8-1:0] reg_wstrb_o,
  input  logic                   reg_ready_i,
  input  logic [DataWidth-1:0]   reg_rdata_i,
  input  logic                   reg_error_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic                   rsp_timeout_o,
  output logic                   busy_o,
  output logic [15:0]            txn_cnt_o,
  output logic [7:0]             err_cnt_o
);

  // The counter only has to reach TimeoutCycles-1: expiry is detected in the
  // last allowed REQ cycle so reg_valid_o is high for exactly TimeoutCycles.
  localparam int CntWidth = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles);
  localparam bit TmoEn    = (TimeoutCycles > 0);
  localparam logic [CntWidth-1:0] TmoLast =
    CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] tmo_q;
  logic                accept, complete, expire, rsp_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    accept      = 1'b0;
    complete    = 1'b0;
    expire      = 1'b0;
    rsp_done    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // A ready arriving on the expiry cycle wins over the timeout.
        if (reg_ready_i) begin
          complete = 1'b1;
          state_d  = RSP;
        end else if (TmoEn && tmo_q == TmoLast) begin
          expire  = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        cmd_ready_o = rsp_ready_i;
        if (rsp_ready_i) begin
          rsp_done = 1'b1;
          if (cmd_valid_i) begin
            accept  = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reg_valid_o = (state_q == REQ);
  assign rsp_valid_o = (state_q == RSP);
  assign busy_o      = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_addr_o    <= '0;
      reg_write_o   <= 1'b0;
      reg_wdata_o   <= '0;
      reg_wstrb_o   <= '0;
      tmo_q         <= '0;
      rsp_rdata_o   <= '0;
      rsp_error_o   <= 1'b0;
      rsp_timeout_o <= 1'b0;
      txn_cnt_o     <= '0;
      err_cnt_o     <= '0;
    end else begin
      if (accept) begin
        reg_addr_o  <= cmd_addr_i;
        reg_write_o <= cmd_write_i;
        reg_wdata_o <= cmd_wdata_i;
        reg_wstrb_o <= cmd_wstrb_i;
        tmo_q       <= '0;
      end else if (state_q == REQ) begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (complete) begin
        rsp_rdata_o   <= reg_write_o ? '0 : reg_rdata_i;
        rsp_error_o   <= reg_error_i;
        rsp_timeout_o <= 1'b0;
      end else if (expire) begin
        rsp_rdata_o   <= '0;
        rsp_error_o   <= 1'b1;
        rsp_timeout_o <= 1'b1;
      end

      if (rsp_done) begin
        txn_cnt_o <= txn_cnt_o + 16'd1;
        if (rsp_error_o && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
module tb_reg_bus_initiator;

  localparam int Tmo = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        reg_valid, reg_write, reg_ready, reg_error;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [15:0] txn_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  reg_bus_initiator #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(Tmo)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_write_i(cmd_write), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .reg_valid_o(reg_valid), .reg_addr_o(reg_addr), .reg_write_o(reg_write),
    .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb), .reg_ready_i(reg_ready),
    .reg_rdata_i(reg_rdata), .reg_error_i(reg_error),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout), .busy_o(busy),
    .txn_cnt_o(txn_cnt), .err_cnt_o(err_cnt)
  );

  typedef struct {
    logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] wstrb;
    int wt; logic err; logic [31:0] rdata; logic hang; logic chk;
  } slv_t;
  typedef struct { logic [31:0] rdata; logic err; logic to; } rsp_t;

  slv_t slv_q[$];
  rsp_t exp_q[$];
  int   n_vec = 0, n_miss = 0, n_pop = 0;
  int   exp_txn = 0, exp_err = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s at %0t", nm, $time);
  endfunction

  // Slave model: one queued behaviour per command, picked up on the first
  // REQ cycle; checks fields every cycle they are presented.
  initial begin : slave
    slv_t cur;
    int   wcnt;
    wcnt = 0;
    cur = '{addr: 0, wr: 0, wdata: 0, wstrb: 0, wt: 0, err: 0, rdata: 0, hang: 0, chk: 0};
    reg_ready = 1'b0; reg_error = 1'b0; reg_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reg_valid === 1'b1) begin
        if (rsp_valid === 1'b1) fail("reg_valid_during_rsp");
        if (wcnt == 0) begin
          if (slv_q.size() == 0) fail("unexpected_reg_req");
          else cur = slv_q.pop_front();
        end
        chk("reg_addr", reg_addr, cur.addr);
        chk("reg_write", {31'b0, reg_write}, {31'b0, cur.wr});
        chk("reg_wdata", reg_wdata, cur.wdata);
        chk("reg_wstrb", {28'b0, reg_wstrb}, {28'b0, cur.wstrb});
        reg_ready = !cur.hang && (wcnt == cur.wt);
        reg_error = reg_ready ? cur.err : 1'b0;
        reg_rdata = reg_ready ? cur.rdata : 32'hBAD0_0000 + wcnt;
        wcnt++;
      end else begin
        if (wcnt > 0 && cur.chk)
          chk(cur.hang ? "timeout_len" : "beat_len", wcnt, cur.hang ? Tmo : cur.wt + 1);
        wcnt = 0;
        reg_ready = 1'b0; reg_error = 1'b0; reg_rdata = 32'h0;
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) fail("unexpected_rsp");
        else begin
          e = exp_q[0];
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
          chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.to});
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            n_pop++;
            exp_txn = (exp_txn + 1) % 65536;
            if (e.err && exp_err != 255) exp_err++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Drives one command and returns at the edge that accepts it.
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input int wt, input logic se,
                      input logic [31:0] rd, input logic hang, input logic ck);
    slv_t sv;
    rsp_t rv;
    int   n;
    sv = '{addr: a, wr: w, wdata: d, wstrb: s, wt: wt, err: se, rdata: rd, hang: hang, chk: ck};
    rv.rdata = (hang || w) ? 32'h0 : rd;
    rv.err   = hang ? 1'b1 : se;
    rv.to    = hang;
    slv_q.push_back(sv);
    exp_q.push_back(rv);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    #1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail("cmd_accept_timeout");
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("drain_timeout");
    @(negedge clk);
    #3;
  endtask

  task automatic check_counts();
    chk("txn_cnt", {16'b0, txn_cnt}, exp_txn);
    chk("err_cnt", {24'b0, err_cnt}, exp_err);
  endtask

  initial begin : stim
    int base;
    rst = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_reg_valid", {31'b0, reg_valid}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    check_counts();

    // Zero-wait write with latency checks.
    send(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle();
    #3;
    chk("lat_reg_valid_n1", {31'b0, reg_valid}, 1);
    chk("lat_rsp_valid_n1", {31'b0, rsp_valid}, 0);
    @(negedge clk);
    #3;
    chk("lat_rsp_valid_n2", {31'b0, rsp_valid}, 1);
    chk("lat_reg_valid_n2", {31'b0, reg_valid}, 0);
    drain();
    check_counts();

    // Read with 3 wait states, slave error, write with error.
    send(32'h0000_0020, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
    send(32'h0000_0024, 1'b0, 32'h0, 4'h1, 0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b1);
    send(32'h0000_0028, 1'b1, 32'hA5A5_0F0F, 4'h6, 1, 1'b1, 32'h7777_7777, 1'b0, 1'b1);
    idle();
    drain();
    check_counts();

    // Timeout, then ready on the expiry cycle.
    send(32'h0000_0030, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h9999_9999, 1'b1, 1'b1);
    idle();
    drain();
    send(32'h0000_0034, 1'b0, 32'h0, 4'hF, Tmo - 1, 1'b0, 32'h55AA_55AA, 1'b0, 1'b1);
    idle();
    drain();
    check_counts();

    // Back-to-back with a 5-cycle stall on the 2nd response.
    base = n_pop;
    fork
      begin
        send(32'h0000_0040, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h1111_1111, 1'b0, 1'b1);
        send(32'h0000_0044, 1'b1, 32'h2222_2222, 4'h3, 0, 1'b0, 32'h0, 1'b0, 1'b1);
        send(32'h0000_0048, 1'b0, 32'h0, 4'hC, 0, 1'b0, 32'h3333_3333, 1'b0, 1'b1);
        idle();
      end
      begin
        int n;
        n = 0;
        while (n_pop < base + 1 && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (n >= 100) fail("b2b_first_rsp_timeout");
        rsp_ready = 1'b0;
        repeat (6) @(negedge clk);
        rsp_ready = 1'b1;
      end
    join
    drain();
    chk("b2b_rsp_count", n_pop - base, 3);
    check_counts();

    // Error counter saturation.
    for (int i = 0; i < 300; i++)
      send(32'h0000_1000 + 4 * i, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'h0100_0000 + i, 1'b0, 1'b1);
    idle();
    drain();
    chk("err_cnt_sat", {24'b0, err_cnt}, 32'hFF);
    check_counts();

    // Reset while the slave stalls.
    send(32'h0000_0050, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    slv_q.delete();
    exp_txn = 0;
    exp_err = 0;
    #3;
    chk("mid_rst_reg_valid", {31'b0, reg_valid}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check_counts();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 0);
    end

    // Normal operation after reset.
    send(32'h0000_0060, 1'b1, 32'h0BAD_F00D, 4'h8, 2, 1'b0, 32'h0, 1'b0, 1'b1);
    idle();
    drain();
    check_counts();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
